mem_port_arbiter: RTL and testbench

- Shares one single-port Hack data-memory port (16-bit words, 15-bit address) between requester A (CPU data side) and requester B (screen/keyboard DMA).
- Contains the select-and-steer datapath: a 2:1 word mux on address, write data and write enable.
- Provides a round-robin arbiter with a bounded hold counter, and returns read data with one cycle of latency to the requester that issued the read.
- Sits between the CPU/DMA engines and the RAM16K-style memory.

---
 rtl/hack_mem_pkg.sv | 16 +
 rtl/word_mux2.sv | 13 +
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared widths, arbiter states and select codes for the Hack memory port
package hack_mem_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/word_mux2.sv
// rtl/word_mux2.sv - DW-wide 2:1 word select (gate-level Mux extended to a bus)
module word_mux2 #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_sel,
    output logic [DW-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin share of one Hack data-memory port between CPU (A) and DMA (B)
module mem_port_arbiter
    import hack_mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          sel
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_last_srv;
    logic          r_sel;
    logic          r_a_rvalid;
    logic          r_b_rvalid;

    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_sel;
    logic          w_beat;
    logic          w_sel_we;

    // Owner keeps the port until its hold budget runs out; an idle tie alternates on last_srv.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (a_req && !b_req) begin
            w_a_gnt = 1'b1;
        end else if (b_req && !a_req) begin
            w_b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            case (r_state)
                ST_OWN_A: begin
                    w_a_gnt = (r_hold < HOLD_MAX);
                    w_b_gnt = (r_hold >= HOLD_MAX);
                end
                ST_OWN_B: begin
                    w_b_gnt = (r_hold < HOLD_MAX);
                    w_a_gnt = (r_hold >= HOLD_MAX);
                end
                default: begin
                    w_a_gnt = (r_last_srv == SEL_B);
                    w_b_gnt = (r_last_srv == SEL_A);
                end
            endcase
        end
    end

    assign w_sel  = w_b_gnt ? SEL_B : (w_a_gnt ? SEL_A : r_sel);
    assign w_beat = w_a_gnt | w_b_gnt;

    word_mux2 #(.DW(AW)) u_addr_mux (
        .i_a   (a_addr),
        .i_b   (b_addr),
        .i_sel (w_sel),
        .o_y   (mem_addr)
    );

    word_mux2 #(.DW(DW)) u_wdata_mux (
        .i_a   (a_wdata),
        .i_b   (b_wdata),
        .i_sel (w_sel),
        .o_y   (mem_wdata)
    );

    word_mux2 #(.DW(1)) u_we_mux (
        .i_a   (a_we),
        .i_b   (b_we),
        .i_sel (w_sel),
        .o_y   (w_sel_we)
    );

    assign mem_we = w_sel_we & w_beat;

    // The hold count only climbs while the other side is actually waiting.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        if (w_a_gnt) begin
            w_state_nxt = ST_OWN_A;
            if (r_state == ST_OWN_A && b_req) begin
                w_hold_nxt = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;
            end else begin
                w_hold_nxt = HOLD_ONE;
            end
        end else if (w_b_gnt) begin
            w_state_nxt = ST_OWN_B;
            if (r_state == ST_OWN_B && a_req) begin
                w_hold_nxt = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;
            end else begin
                w_hold_nxt = HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_last_srv <= SEL_B;
            r_sel      <= SEL_A;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_sel      <= w_sel;
            if (w_beat) begin
                r_last_srv <= w_sel;
            end
            r_a_rvalid <= w_a_gnt & ~a_we;
            r_b_rvalid <= w_b_gnt & ~b_we;
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign sel      = w_sel;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [14:0] a_addr, b_addr, mem_addr;
    logic [15:0] a_wdata, b_wdata, mem_wdata, mem_rdata, rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, sel;

    mem_port_arbiter #(.AW(15), .DW(16), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // e = {a_gnt, b_gnt, sel, mem_we, a_rvalid, b_rvalid}
    typedef struct {
        string       nm;
        logic [5:0]  e;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic rn,
                       input logic ar, input logic aw, input logic [14:0] aa,
                       input logic br, input logic bw, input logic [14:0] ba,
                       input logic [5:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        reset_n   = rn;
        a_req     = ar;
        a_we      = aw;
        a_addr    = aa;
        a_wdata   = {1'b1, aa};
        b_req     = br;
        b_we      = bw;
        b_addr    = ba;
        b_wdata   = ~{1'b0, ba};
        mem_rdata = 16'hC000 | 16'(cyc_n);
        cyc_n++;
        x.nm    = nm;
        x.e     = e;
        x.addr  = e[3] ? ba : aa;
        x.wdata = e[3] ? b_wdata : a_wdata;
        x.rdata = mem_rdata;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk({x.nm, ":gnt"},    {30'd0, a_gnt, b_gnt},       {30'd0, x.e[5:4]});
                chk({x.nm, ":sel"},    {31'd0, sel},                {31'd0, x.e[3]});
                chk({x.nm, ":we"},     {31'd0, mem_we},             {31'd0, x.e[2]});
                chk({x.nm, ":rvalid"}, {30'd0, a_rvalid, b_rvalid}, {30'd0, x.e[1:0]});
                chk({x.nm, ":addr"},   {17'd0, mem_addr},           {17'd0, x.addr});
                chk({x.nm, ":wdata"},  {16'd0, mem_wdata},          {16'd0, x.wdata});
                if (a_rvalid || b_rvalid)
                    chk({x.nm, ":rdata"}, {16'd0, rdata}, {16'd0, x.rdata});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : driver
        reset_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; mem_rdata = '0;

        cyc("rst0", 0, 0, 0, 15'h0020, 0, 0, 15'h0030, 6'b000000);
        cyc("rst1", 0, 0, 0, 15'h0020, 0, 0, 15'h0030, 6'b000000);

        // Released with both writing: AAAA BBBB AAAA
        for (int i = 0; i < 12; i++) begin
            if (i < 4 || i >= 8)
                cyc($sformatf("fair%0d", i), 1, 1, 1, 15'h0020, 1, 1, 15'h0030, 6'b100100);
            else
                cyc($sformatf("fair%0d", i), 1, 1, 1, 15'h0020, 1, 1, 15'h0030, 6'b011100);
        end
        cyc("idle0", 1, 0, 0, 15'h0020, 0, 0, 15'h0030, 6'b000000);

        cyc("rdA0",  1, 1, 0, 15'h0010, 0, 0, 15'h0030, 6'b100000);
        cyc("rdA1",  1, 1, 0, 15'h0010, 0, 0, 15'h0030, 6'b100010);
        cyc("rdA2",  1, 1, 0, 15'h0010, 0, 0, 15'h0030, 6'b100010);
        cyc("rdA3",  1, 0, 0, 15'h0010, 0, 0, 15'h0030, 6'b000010);
        cyc("idle1", 1, 0, 0, 15'h0010, 0, 0, 15'h0030, 6'b000000);

        // A reaches hold 2, drops; B must get a fresh hold of 1 (four B beats)
        cyc("ho1", 1, 1, 1, 15'h0100, 0, 1, 15'h4000, 6'b100100);
        cyc("ho2", 1, 1, 1, 15'h0100, 1, 1, 15'h4000, 6'b100100);
        cyc("ho3", 1, 0, 1, 15'h0100, 1, 1, 15'h4000, 6'b011100);
        cyc("ho4", 1, 1, 1, 15'h0100, 1, 1, 15'h4000, 6'b011100);
        cyc("ho5", 1, 1, 1, 15'h0100, 1, 1, 15'h4000, 6'b011100);
        cyc("ho6", 1, 1, 1, 15'h0100, 1, 1, 15'h4000, 6'b011100);
        cyc("ho7", 1, 1, 1, 15'h0100, 1, 1, 15'h4000, 6'b100100);
        cyc("idle2", 1, 0, 0, 15'h0100, 0, 0, 15'h4000, 6'b000000);

        cyc("il1", 1, 1, 0, 15'h0100, 0, 0, 15'h4000, 6'b100000);
        cyc("il2", 1, 0, 0, 15'h0100, 1, 0, 15'h4000, 6'b011010);
        cyc("il3", 1, 0, 0, 15'h0100, 0, 0, 15'h4000, 6'b001001);
        cyc("il4", 1, 0, 0, 15'h0100, 0, 0, 15'h4000, 6'b001000);

        // B read beat, then reset lands before the edge that would raise b_rvalid
        cyc("mr1", 1, 0, 0, 15'h0200, 1, 0, 15'h4001, 6'b011000);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        cyc("mr2", 0, 0, 0, 15'h0200, 0, 0, 15'h4001, 6'b000000);
        cyc("mr3", 1, 1, 0, 15'h0200, 1, 0, 15'h4001, 6'b100000);
        cyc("mr4", 1, 1, 0, 15'h0200, 1, 0, 15'h4001, 6'b100010);
        cyc("mr5", 1, 0, 0, 15'h0200, 0, 0, 15'h4001, 6'b000010);
        cyc("mr6", 1, 0, 0, 15'h0200, 0, 0, 15'h4001, 6'b000000);

        repeat (3) @(posedge clk);
        chk("drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
